// File: rtl/cd_fifo_obuf.sv
// cd_fifo_obuf: 2-entry show-ahead output buffer (head + skid) behind the RAM read port
//   clk, reset_n     : clock, asynchronous active-low reset
//   clear            : synchronous flush, discards any word being loaded
//   load, load_data  : word returning from the RAM this cycle
//   pop              : consumer removes head (caller guarantees occ != 0)
//   head, occ        : head word and number of held words (0..2)
module cd_fifo_obuf #(
    parameter D_WIDTH = 8
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic               clear,
    input  logic               load,
    input  logic [D_WIDTH-1:0] load_data,
    input  logic               pop,
    output logic [D_WIDTH-1:0] head,
    output logic [1:0]         occ
);
    logic [D_WIDTH-1:0] skid;
    logic [1:0]         base;
    // occupancy after this cycle's pop; the loaded word lands in the first free slot
    assign base = occ - {1'b0, pop};
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            occ  <= '0;
            head <= '0;
            skid <= '0;
        end else if (clear) begin
            occ <= '0;
        end else begin
            occ  <= base + {1'b0, load};
            head <= (load && base == 2'd0) ? load_data : (pop && occ == 2'd2) ? skid : head;
            if (load && base == 2'd1) skid <= load_data;
        end
    end
endmodule

// File: rtl/cd_fifo_ctrl.sv
// cd_fifo_ctrl: synchronous FIFO controller driving an external 1-cycle-latency SDP RAM
//   clk, reset_n              : clock, asynchronous active-low reset
//   clear                     : synchronous flush
//   in_data/in_valid/in_ready : write stream
//   out_data/out_valid/out_ready : show-ahead read stream
//   count, full, empty        : total words held, RAM region full, nothing held
//   ram_cen/ram_wen           : RAM chip/write enables, active low
//   ram_ra/ram_rd             : RAM read address / data (data one cycle after issue)
//   ram_wa/ram_wd             : RAM write address / data
module cd_fifo_ctrl #(
    parameter A_WIDTH = 8,
    parameter D_WIDTH = 8
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic               clear,
    input  logic [D_WIDTH-1:0] in_data,
    input  logic               in_valid,
    output logic               in_ready,
    output logic [D_WIDTH-1:0] out_data,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [A_WIDTH+1:0] count,
    output logic               full,
    output logic               empty,
    output logic               ram_cen,
    output logic [A_WIDTH-1:0] ram_ra,
    input  logic [D_WIDTH-1:0] ram_rd,
    output logic [A_WIDTH-1:0] ram_wa,
    output logic [D_WIDTH-1:0] ram_wd,
    output logic               ram_wen
);
    localparam int DEPTH = 2 ** A_WIDTH;
    localparam int PTR_W = A_WIDTH + 1;
    localparam int CNT_W = A_WIDTH + 2;
    logic [PTR_W-1:0] wr_ptr, rd_ptr, ram_cnt;
    logic             inflight, push, pop, rd_en;
    logic [1:0]       occ;
    // extra pointer MSB separates full from empty
    assign ram_cnt   = wr_ptr - rd_ptr;
    assign full      = ram_cnt == PTR_W'(DEPTH);
    assign in_ready  = !full && !clear;
    assign push      = in_valid && in_ready;
    assign out_valid = occ != 2'd0;
    assign pop       = out_valid && out_ready;
    // issue a read only if the buffer can take the word when it returns
    assign rd_en     = ram_cnt != '0 && !clear && ({1'b0, occ} + {2'b0, inflight} < 3'd2 + {2'b0, pop});
    assign empty     = count == '0;
    assign ram_cen   = !(push || rd_en);
    assign ram_wen   = !push;
    assign ram_wa    = wr_ptr[A_WIDTH-1:0];
    assign ram_wd    = in_data;
    assign ram_ra    = rd_ptr[A_WIDTH-1:0];
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            inflight <= 1'b0;
            count    <= '0;
        end else if (clear) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            inflight <= 1'b0;
            count    <= '0;
        end else begin
            wr_ptr   <= wr_ptr + PTR_W'(push);
            rd_ptr   <= rd_ptr + PTR_W'(rd_en);
            inflight <= rd_en;
            count    <= count + CNT_W'(push) - CNT_W'(pop);
        end
    end
    cd_fifo_obuf #(.D_WIDTH(D_WIDTH)) u_obuf (
        .clk      (clk),
        .reset_n  (reset_n),
        .clear    (clear),
        .load     (inflight),
        .load_data(ram_rd),
        .pop      (pop),
        .head     (out_data),
        .occ      (occ)
    );
endmodule
